// File: rtl/xmod_arbiter_if.sv
// Request/response bundle between NREQ producers and the shared xmod adder arbiter.
// master = producer/consumer side, slave = arbiter side.
interface xmod_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 8,
    parameter int OUT_W = 4,
    parameter int IDX_W = 3,
    parameter int CNT_W = 16
);
    logic [NREQ-1:0]      REQ_VALID;
    logic [NREQ*IN_W-1:0] REQ_A;
    logic [NREQ*IN_W-1:0] REQ_B;
    logic [NREQ-1:0]      REQ_READY;
    logic                 RES_VALID;
    logic [OUT_W-1:0]     RES_DATA;
    logic [IDX_W-1:0]     RES_ID;
    logic                 RES_READY;
    logic                 BUSY;
    logic [CNT_W-1:0]     OPS_CNT;

    modport master (
        output REQ_VALID, REQ_A, REQ_B, RES_READY,
        input  REQ_READY, RES_VALID, RES_DATA, RES_ID, BUSY, OPS_CNT
    );

    modport slave (
        input  REQ_VALID, REQ_A, REQ_B, RES_READY,
        output REQ_READY, RES_VALID, RES_DATA, RES_ID, BUSY, OPS_CNT
    );
endinterface

// File: rtl/xmod_arbiter.sv
// Round-robin arbiter sharing one truncating adder between NREQ requesters.
// One operation in flight at a time: IDLE (grant) -> EXEC (add) -> RESP (hold result).
module xmod_arbiter #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 8,
    parameter int OUT_W = 4,
    parameter int IDX_W = 3,
    parameter int CNT_W = 16
) (
    input logic            CLK,
    input logic            RST,
    xmod_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] id_q;
    logic [IN_W-1:0]  a_q;
    logic [IN_W-1:0]  b_q;
    logic             res_valid_q;
    logic [OUT_W-1:0] res_data_q;
    logic [IDX_W-1:0] res_id_q;
    logic [CNT_W-1:0] ops_cnt_q;

    logic [NREQ-1:0]  grant_d;
    logic [IDX_W-1:0] grant_idx_d;
    logic [IN_W-1:0]  a_d;
    logic [IN_W-1:0]  b_d;
    logic [OUT_W-1:0] sum_d;
    logic [NREQ-1:0]  onehot;
    int               idx;

    // Scan from LAST+NREQ down to LAST+1 so the candidate nearest after LAST wins last.
    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        grant_d     = '0;
        grant_idx_d = '0;
        onehot      = '0;
        idx         = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx    = (int'(last_q) + k) % NREQ;
            onehot = NREQ'(1) << idx;
            if (|(bus.REQ_VALID & onehot)) begin
                grant_d     = onehot;
                grant_idx_d = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        a_d = '0;
        b_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_d[i]) begin
                a_d = bus.REQ_A[i*IN_W +: IN_W];
                b_d = bus.REQ_B[i*IN_W +: IN_W];
            end
        end
    end

    // Carry and upper sum bits are dropped on purpose.
    assign sum_d = OUT_W'(a_q + b_q);

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NREQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            ops_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|grant_d) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        id_q    <= grant_idx_d;
                        last_q  <= grant_idx_d;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    res_data_q  <= sum_d;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.RES_READY) begin
                        res_valid_q <= 1'b0;
                        ops_cnt_q   <= ops_cnt_q + CNT_W'(1);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.REQ_READY = (state_q == IDLE) ? grant_d : '0;
    assign bus.RES_VALID = res_valid_q;
    assign bus.RES_DATA  = res_data_q;
    assign bus.RES_ID    = res_id_q;
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.OPS_CNT   = ops_cnt_q;

endmodule

// File: tb/tb_xmod_arbiter.sv
// Directed bench for xmod_arbiter: expected results are queued when a grant is
// expected and popped by a monitor on every result handoff.
module tb_xmod_arbiter;

    localparam int NREQ  = 4;
    localparam int IN_W  = 8;
    localparam int OUT_W = 4;
    localparam int IDX_W = 3;
    localparam int CNT_W = 16;

    typedef struct {
        logic [IDX_W-1:0] id;
        logic [OUT_W-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    logic [IN_W-1:0]  a_arr [NREQ];
    logic [IN_W-1:0]  b_arr [NREQ];
    exp_t             sb [$];
    logic [CNT_W-1:0] exp_cnt;
    int               checks;
    int               errors;

    xmod_arbiter_if #(
        .NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) bus ();

    xmod_arbiter #(
        .NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.REQ_A = '0;
        bus.REQ_B = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.REQ_A[i*IN_W +: IN_W] = a_arr[i];
            bus.REQ_B[i*IN_W +: IN_W] = b_arr[i];
        end
    end

    function automatic logic [OUT_W-1:0] model_sum(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
        logic [IN_W:0] full;
        full = {1'b0, a} + {1'b0, b};
        return full[OUT_W-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_res(input int id);
        exp_t e;
        e.id   = IDX_W'(id);
        e.data = model_sum(a_arr[id], b_arr[id]);
        sb.push_back(e);
    endtask

    // Pops one expectation per handoff (RES_VALID & RES_READY seen before the edge).
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0 && bus.RES_VALID === 1'b1 && bus.RES_READY === 1'b1) begin
                exp_cnt++;
                check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sb_res_id", 32'(bus.RES_ID), 32'(e.id));
                    check("sb_res_data", 32'(bus.RES_DATA), 32'(e.data));
                end
            end
        end
    endtask

    task automatic run_single(input int i, input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
        step();
        a_arr[i]      = a;
        b_arr[i]      = b;
        bus.REQ_VALID = NREQ'(1) << i;
        bus.RES_READY = 1'b0;
        #1;
        check("single_grant", 32'(bus.REQ_READY), 32'(NREQ'(1) << i));
        expect_res(i);
        step();
        bus.REQ_VALID = '0;
        #1;
        check("single_exec_busy", 32'(bus.BUSY), 32'd1);
        check("single_exec_valid", 32'(bus.RES_VALID), 32'd0);
        check("single_exec_ready", 32'(bus.REQ_READY), 32'd0);
        step();
        bus.RES_READY = 1'b1;
        #1;
        check("single_res_valid", 32'(bus.RES_VALID), 32'd1);
        check("single_res_data", 32'(bus.RES_DATA), 32'(model_sum(a, b)));
        check("single_res_id", 32'(bus.RES_ID), 32'(i));
        step();
        bus.RES_READY = 1'b0;
        #1;
        check("single_done_valid", 32'(bus.RES_VALID), 32'd0);
        check("single_done_busy", 32'(bus.BUSY), 32'd0);
        check("single_done_cnt", 32'(bus.OPS_CNT), 32'(exp_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        exp_cnt       = '0;
        rst           = 1'b1;
        bus.REQ_VALID = '0;
        bus.RES_READY = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        fork
            monitor();
        join_none

        // Reset state
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_res_valid", 32'(bus.RES_VALID), 32'd0);
        check("rst_res_data", 32'(bus.RES_DATA), 32'd0);
        check("rst_res_id", 32'(bus.RES_ID), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_ops_cnt", 32'(bus.OPS_CNT), 32'd0);
        check("rst_req_ready", 32'(bus.REQ_READY), 32'd0);

        // Single request and truncation cases
        run_single(2, 8'h13, 8'h05);
        check("single_data_literal", 32'(bus.RES_DATA), 32'h8);
        run_single(0, 8'hFF, 8'h02);
        check("trunc_ff_02", 32'(bus.RES_DATA), 32'h1);
        run_single(3, 8'h0F, 8'h01);
        check("trunc_0f_01", 32'(bus.RES_DATA), 32'h0);

        // Reset mid-EXEC aborts the operation
        step();
        a_arr[1]      = 8'h44;
        b_arr[1]      = 8'h11;
        bus.REQ_VALID = 4'b0010;
        bus.RES_READY = 1'b1;
        #1;
        check("abort_grant", 32'(bus.REQ_READY), 32'b0010);
        step();
        bus.REQ_VALID = '0;
        rst           = 1'b1;
        #1;
        check("abort_in_exec", 32'(bus.BUSY), 32'd1);
        step();
        #1;
        check("abort_res_valid", 32'(bus.RES_VALID), 32'd0);
        check("abort_busy", 32'(bus.BUSY), 32'd0);
        check("abort_ops_cnt", 32'(bus.OPS_CNT), 32'd0);
        step();
        rst     = 1'b0;
        exp_cnt = '0;
        for (int n = 0; n < 4; n++) begin
            step();
            #1;
            check("abort_no_result", 32'(bus.RES_VALID), 32'd0);
        end

        // Round robin with all requesters active
        step();
        a_arr[0] = 8'h21; b_arr[0] = 8'h35;
        a_arr[1] = 8'h9C; b_arr[1] = 8'h07;
        a_arr[2] = 8'hE7; b_arr[2] = 8'h2A;
        a_arr[3] = 8'h40; b_arr[3] = 8'hC9;
        bus.REQ_VALID = 4'b1111;
        bus.RES_READY = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_grant", 32'(bus.REQ_READY), 32'(NREQ'(1) << (k % NREQ)));
            expect_res(k % NREQ);
            step();
            #1;
            check("rr_exec_valid", 32'(bus.RES_VALID), 32'd0);
            step();
            #1;
            check("rr_resp_valid", 32'(bus.RES_VALID), 32'd1);
            check("rr_resp_id", 32'(bus.RES_ID), 32'(k % NREQ));
            step();
            if (k == 4) bus.REQ_VALID = '0;
        end
        #1;
        check("rr_ops_cnt", 32'(bus.OPS_CNT), 32'd5);
        check("rr_idle_ready", 32'(bus.REQ_READY), 32'd0);

        // Backpressure: result held, no grants while RES_READY is low
        step();
        a_arr[2] = 8'h5A; b_arr[2] = 8'h3C;
        a_arr[3] = 8'h7A; b_arr[3] = 8'h19;
        bus.REQ_VALID = 4'b1100;
        bus.RES_READY = 1'b0;
        #1;
        check("bp_grant", 32'(bus.REQ_READY), 32'b0100);
        expect_res(2);
        step();
        bus.REQ_VALID = 4'b1000;
        #1;
        check("bp_exec_ready", 32'(bus.REQ_READY), 32'd0);
        step();
        #1;
        check("bp_resp_valid", 32'(bus.RES_VALID), 32'd1);
        for (int n = 0; n < 10; n++) begin
            step();
            #1;
            check("bp_hold_valid", 32'(bus.RES_VALID), 32'd1);
            check("bp_hold_data", 32'(bus.RES_DATA), 32'(model_sum(8'h5A, 8'h3C)));
            check("bp_hold_id", 32'(bus.RES_ID), 32'd2);
            check("bp_hold_ready", 32'(bus.REQ_READY), 32'd0);
        end
        step();
        bus.RES_READY = 1'b1;
        step();
        #1;
        check("bp_release_valid", 32'(bus.RES_VALID), 32'd0);
        check("bp_next_grant", 32'(bus.REQ_READY), 32'b1000);
        expect_res(3);
        step();
        bus.REQ_VALID = '0;
        step();
        step();
        #1;
        check("bp_done_busy", 32'(bus.BUSY), 32'd0);

        // Withdrawn pulse while busy is never granted
        step();
        a_arr[0] = 8'h31; b_arr[0] = 8'h42;
        bus.REQ_VALID = 4'b0001;
        #1;
        check("wd_grant", 32'(bus.REQ_READY), 32'b0001);
        expect_res(0);
        step();
        bus.REQ_VALID = 4'b0010;
        #1;
        check("wd_pulse_ready", 32'(bus.REQ_READY), 32'd0);
        step();
        bus.REQ_VALID = '0;
        #1;
        check("wd_resp_valid", 32'(bus.RES_VALID), 32'd1);
        step();
        #1;
        check("wd_idle_busy", 32'(bus.BUSY), 32'd0);
        check("wd_idle_ready", 32'(bus.REQ_READY), 32'd0);
        step();
        #1;
        check("wd_no_grant", 32'(bus.BUSY), 32'd0);
        step();
        #1;
        check("wd_no_result", 32'(bus.RES_VALID), 32'd0);

        // Counter wrap
        step();
        force dut.ops_cnt_q = 16'hFFFF;
        #1;
        release dut.ops_cnt_q;
        exp_cnt = 16'hFFFF;
        check("wrap_forced", 32'(bus.OPS_CNT), 32'hFFFF);
        run_single(1, 8'h08, 8'h09);
        check("wrap_ops_cnt", 32'(bus.OPS_CNT), 32'h0000);

        step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
